// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: multi-cycle mult/div with HI/LO registers,
// mthi/mtlo moves, and a busy flag for the D-stage stall logic.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             busy_d;
  logic [31:0]      hi_d, lo_d;
  logic [31:0]      res_hi, res_hi_d, res_lo, res_lo_d;
  logic             res_wr, res_wr_d;

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  // Operand-side arithmetic, evaluated on the start cycle and latched into res_*.
  always_comb begin
    prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u = {32'd0, A} * {32'd0, B};
    a_neg  = (op == OP_DIV) && A[31];
    b_neg  = (op == OP_DIV) && B[31];
    a_mag  = a_neg ? 32'(-A) : A;
    b_mag  = b_neg ? 32'(-B) : B;
    // Divisor forced nonzero so the divider never sees 0; the result is discarded then.
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (a_neg ^ b_neg) ? 32'(-q_mag) : q_mag;
    rem    = a_neg ? 32'(-r_mag) : r_mag;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    busy_d   = busy;
    hi_d     = HI;
    lo_d     = LO;
    res_hi_d = res_hi;
    res_lo_d = res_lo;
    res_wr_d = res_wr;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              res_hi_d = (op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
              res_lo_d = (op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
              res_wr_d = 1'b1;
              cnt_d    = MULT_LOAD;
              state_d  = RUN;
              busy_d   = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              res_hi_d = rem;
              res_lo_d = quot;
              res_wr_d = (B != 32'd0);
              cnt_d    = DIV_LOAD;
              state_d  = RUN;
              busy_d   = 1'b1;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt - CNT_LAST;
        if (cnt == CNT_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (res_wr) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      HI     <= 32'd0;
      LO     <= 32'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      res_wr <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      busy   <= busy_d;
      HI     <= hi_d;
      LO     <= lo_d;
      res_hi <= res_hi_d;
      res_lo <= res_lo_d;
      res_wr <= res_wr_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus random ops against
// an arithmetic reference model of HI/LO and busy duration.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(rst_n), .start(start), .op(op),
    .A(a), .B(b), .busy(busy), .HI(hi), .LO(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: HI/LO after an op, from plain integer arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, sp, sq, sr;
    longint unsigned ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: begin sp = sx * sy; exp_hi = sp[63:32]; exp_lo = sp[31:0]; end
      3'd1: begin up = ux * uy; exp_hi = up[63:32]; exp_lo = up[31:0]; end
      3'd2: if (y != 0) begin
        sq = sx / sy; sr = sx % sy;
        exp_lo = sq[31:0]; exp_hi = sr[31:0];
      end
      3'd3: if (y != 0) begin
        up = ux / uy; exp_lo = up[31:0];
        up = ux % uy; exp_hi = up[31:0];
      end
      3'd4: exp_hi = x;
      3'd5: exp_lo = x;
      default: ;
    endcase
  endtask

  function automatic int exp_cycles(input logic [2:0] o);
    if (o <= 3'd1) return MULT_N;
    if (o <= 3'd3) return DIV_N;
    return 0;
  endfunction

  // Present one op for a single cycle, then scramble operands to prove capture.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
  endtask

  // Count busy cycles from the current negedge; -1 on timeout.
  task automatic count_busy(input int already, output int cycles);
    cycles = already;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 200) cycles = -1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int cycles);
    issue(o, x, y);
    count_busy(0, cycles);
    model(o, x, y);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_mult;
    int c;
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, c);
    n_checks++;
    if (c !== MULT_N || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      n_fail++;
      $display("FAIL mult_signed: cycles=%0d hi=%h lo=%h, required %0d ffffffff fffffff1", c, hi, lo, MULT_N);
    end
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, c);
    n_checks++;
    if (c !== MULT_N || hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL multu: cycles=%0d hi=%h lo=%h, required %0d 00000001 fffffffe", c, hi, lo, MULT_N);
    end
  endtask

  task automatic test_div;
    int c;
    run_op(3'd3, 32'd100, 32'd7, c);
    n_checks++;
    if (c !== DIV_N || lo !== 32'd14 || hi !== 32'd2) begin
      n_fail++;
      $display("FAIL divu: cycles=%0d hi=%h lo=%h, required %0d 2 14", c, hi, lo, DIV_N);
    end
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, c);
    n_checks++;
    if (c !== DIV_N || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL div_neg: cycles=%0d hi=%h lo=%h, required fffffffd/ffffffff", c, hi, lo);
    end
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, c);
    n_checks++;
    if (c !== DIV_N || lo !== 32'h8000_0000 || hi !== 32'd0) begin
      n_fail++;
      $display("FAIL div_overflow: cycles=%0d hi=%h lo=%h, required 0/80000000", c, hi, lo);
    end
  endtask

  task automatic test_div_zero;
    int c;
    run_op(3'd4, 32'hAAAA, 32'd0, c);
    run_op(3'd5, 32'h5555, 32'd0, c);
    n_checks++;
    if (hi !== 32'hAAAA || lo !== 32'h5555) begin
      n_fail++;
      $display("FAIL preload: hi=%h lo=%h, required aaaa/5555", hi, lo);
    end
    run_op(3'd2, 32'd1234, 32'd0, c);
    n_checks++;
    if (c !== DIV_N || hi !== 32'hAAAA || lo !== 32'h5555) begin
      n_fail++;
      $display("FAIL div_by_zero: cycles=%0d hi=%h lo=%h, required %0d aaaa 5555", c, hi, lo, DIV_N);
    end
    run_op(3'd3, 32'hFFFF_0000, 32'd0, c);
    n_checks++;
    if (c !== DIV_N || hi !== 32'hAAAA || lo !== 32'h5555) begin
      n_fail++;
      $display("FAIL divu_by_zero: cycles=%0d hi=%h lo=%h, required %0d aaaa 5555", c, hi, lo, DIV_N);
    end
  endtask

  task automatic test_move_and_ignore;
    int c;
    issue(3'd4, 32'h1234, 32'd0);
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h1234) begin
      n_fail++;
      $display("FAIL mthi: busy=%b hi=%h, required 0 1234", busy, hi);
    end
    model(3'd4, 32'h1234, 32'd0);
    issue(3'd0, 32'd2, 32'd3);
    // now in busy cycle 1; inject mtlo during busy cycle 2
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'd9;
    @(negedge clk);
    start = 1'b0;
    count_busy(2, c);
    model(3'd0, 32'd2, 32'd3);
    n_checks++;
    if (c !== MULT_N || hi !== 32'd0 || lo !== 32'd6) begin
      n_fail++;
      $display("FAIL start_in_run: cycles=%0d hi=%h lo=%h, required %0d 0 6", c, hi, lo, MULT_N);
    end
    issue(3'd6, 32'h77, 32'h88);
    issue(3'd7, 32'h77, 32'h88);
    n_checks++;
    if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      n_fail++;
      $display("FAIL nop_op: busy=%b hi=%h lo=%h, required 0 %h %h", busy, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset_mid;
    int c;
    run_op(3'd4, 32'h1111, 32'd0, c);
    run_op(3'd5, 32'h2222, 32'd0, c);
    issue(3'd2, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
    end
    exp_hi = 32'd0; exp_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
    end
    run_op(3'd1, 32'h0001_0000, 32'h0001_0000, c);
    n_checks++;
    if (c !== MULT_N || hi !== 32'd1 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset_op: cycles=%0d hi=%h lo=%h, required %0d 1 0", c, hi, lo, MULT_N);
    end
  endtask

  task automatic test_random;
    int c;
    logic [2:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 20));
        3: y = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: ;
      endcase
      run_op(o, x, y, c);
      n_checks++;
      if (c !== exp_cycles(o) || hi !== exp_hi || lo !== exp_lo) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: cycles=%0d hi=%h lo=%h, required %0d %h %h",
                 i, o, x, y, c, hi, lo, exp_cycles(o), exp_hi, exp_lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_move_and_ignore();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
